lcd_bus_ctrl: RTL

Parametrised HD44780-class LCD write controller that generalises the single-shot start/done LCD writer. Adds a valid/ready command interface, programmable setup/enable/hold timing, 8-bit or 4-bit (two-nibble) bus mode, and per-command execution wait with a long wait for clear/home. Sits between the LCD init/text sequencer and the LCD pins.

---
 rtl/lcd_bus_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_ctrl.sv
// HD44780-class LCD write controller: valid/ready byte in, timed RS/RW/EN/DATA strobes out, 8- or 4-bit bus.
// Latency: oDone at cycle T_SETUP+T_PULSE+T_HOLD (x2 in 4-bit mode) + wait + 1 after acceptance.
// Backpressure: oReady low from the cycle after acceptance until the cycle after oDone; no queueing.
// Optional: define LCD_BUSYPOLL_EN to replace the fixed execution wait with busy-flag polling.
module lcd_bus_ctrl #(
  parameter int BUS_4BIT = 0,
  parameter int T_SETUP  = 2,
  parameter int T_PULSE  = 16,
  parameter int T_HOLD   = 2,
  parameter int T_CMD    = 2000,
  parameter int T_LONG   = 82000,
  parameter int CNT_W    = 17
`ifdef LCD_BUSYPOLL_EN
  ,
  parameter int POLL_MAX = 1000
`endif
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oDone,
`ifdef LCD_BUSYPOLL_EN
  input  logic       iLCD_BF,
  output logic       oLCD_OE,
  output logic       oErr,
`endif
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic       LCD_RS
);

  // Zero-length phases are stretched to one cycle so every state is visited.
  localparam int TS = (T_SETUP < 1) ? 1 : T_SETUP;
  localparam int TP = (T_PULSE < 1) ? 1 : T_PULSE;
  localparam int TH = (T_HOLD  < 1) ? 1 : T_HOLD;
  localparam int TC = (T_CMD   < 1) ? 1 : T_CMD;
  localparam int TL = (T_LONG  < 1) ? 1 : T_LONG;

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(TS - 1);
  localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(TP - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(TH - 1);
  localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(TC - 1);
  localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(TL - 1);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_DONE
  } state_t;

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             w_cnt_zero;
  logic             w_nib_load;
  logic             w_accept;
  logic             r_nib;     // second nibble of a 4-bit transfer in progress
  logic             r_long;    // clear/home command: long execution wait
  logic [3:0]       r_lo;      // low nibble kept for the second 4-bit transfer
  logic [7:0]       r_data;
  logic             r_en, r_rs, r_ready, r_done;

`ifdef LCD_BUSYPOLL_EN
  localparam int RD_W = $clog2(POLL_MAX + 1);
  logic            r_poll, r_bf, r_rw, r_oe, r_err;
  logic [RD_W-1:0] r_reads;
`endif

  assign w_cnt_zero = (r_cnt == '0);
  assign w_accept   = (r_state == S_IDLE) && iValid;

  // State and shared delay counter register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next state; the counter is reloaded with (phase length - 1) on every state entry
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = w_cnt_zero ? '0 : (r_cnt - L_ONE);
    w_nib_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iValid) begin
          w_state_nx = S_SETUP;
          w_cnt_nx   = L_SETUP;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nx = S_PULSE;
          w_cnt_nx   = L_PULSE;
        end
      end
      S_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nx = S_HOLD;
          w_cnt_nx   = L_HOLD;
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          if ((BUS_4BIT != 0) && !r_nib) begin
            w_state_nx = S_SETUP;
            w_cnt_nx   = L_SETUP;
            w_nib_load = 1'b1;
          end
`ifdef LCD_BUSYPOLL_EN
          else if (!r_poll || (r_bf && (r_reads < RD_W'(POLL_MAX)))) begin
            w_state_nx = S_SETUP;
            w_cnt_nx   = L_SETUP;
          end else begin
            w_state_nx = S_DONE;
          end
`else
          else begin
            w_state_nx = S_WAIT;
            w_cnt_nx   = r_long ? L_LONG : L_CMD;
          end
`endif
        end
      end
      S_WAIT: begin
        if (w_cnt_zero) w_state_nx = S_DONE;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Registered pin outputs and the byte latched at acceptance
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_lo    <= 4'h0;
      r_nib   <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_ready <= (w_state_nx == S_IDLE);
      r_done  <= (w_state_nx == S_DONE);
      r_en    <= (w_state_nx == S_PULSE);
      if (w_accept) begin
        r_data <= (BUS_4BIT != 0) ? {iDATA[7:4], 4'h0} : iDATA;
        r_lo   <= iDATA[3:0];
        r_rs   <= iRS;
        r_nib  <= 1'b0;
        // Clear (0x01) and home (0x02/0x03) need the long execution wait
        r_long <= !iRS && (iDATA[7:2] == 6'd0) && (iDATA[1:0] != 2'd0);
      end else if (w_nib_load) begin
        r_nib <= 1'b1;
`ifdef LCD_BUSYPOLL_EN
        if (!r_poll) r_data <= {r_lo, 4'h0};
`else
        r_data <= {r_lo, 4'h0};
`endif
      end
`ifdef LCD_BUSYPOLL_EN
      else if ((r_state == S_HOLD) && (w_state_nx == S_SETUP)) begin
        // Start (or repeat) a busy-flag read cycle
        r_nib  <= 1'b0;
        r_poll <= 1'b1;
        r_rs   <= 1'b0;
        r_rw   <= 1'b1;
        r_oe   <= 1'b0;
      end
`endif
    end
  end

`ifdef LCD_BUSYPOLL_EN
  // Busy-flag sampling, read counting and bus direction during polling
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_poll  <= 1'b0;
      r_bf    <= 1'b0;
      r_rw    <= 1'b0;
      r_oe    <= 1'b1;
      r_err   <= 1'b0;
      r_reads <= '0;
    end else begin
      r_err <= (w_state_nx == S_DONE) && r_bf;
      if (w_accept) begin
        r_poll  <= 1'b0;
        r_bf    <= 1'b0;
        r_reads <= '0;
      end
      if (r_poll && (r_state == S_PULSE) && w_cnt_zero && !r_nib) begin
        r_bf    <= iLCD_BF;
        r_reads <= r_reads + RD_W'(1);
      end
      if (w_state_nx == S_DONE) begin
        r_rw <= 1'b0;
        r_oe <= 1'b1;
      end
    end
  end

  assign oLCD_OE = r_oe;
  assign oErr    = r_err;
  assign LCD_RW  = r_rw;
`else
  assign LCD_RW  = 1'b0;
`endif

  assign oReady   = r_ready;
  assign oDone    = r_done;
  assign LCD_DATA = r_data;
  assign LCD_EN   = r_en;
  assign LCD_RS   = r_rs;

endmodule
